// File: rtl/lap_sequencer.sv
// Stopwatch control: drives counter_core enable/clear, captures laps into a
// circular buffer and muxes live or stored time onto the display bus.
module lap_sequencer #(
   parameter int LAP_DEPTH = 8,
   parameter int IDX_W     = 3
) (
   input  logic             clk_core,
   input  logic             rst,
   input  logic             start_stop,
   input  logic             lap_reset,
   input  logic             review,
   input  logic [5:0]       min_i,
   input  logic [5:0]       sec_i,
   input  logic [6:0]       ms_10_i,
   output logic             cnt_en,
   output logic             cnt_clr,
   output logic [5:0]       min_o,
   output logic [5:0]       sec_o,
   output logic [6:0]       ms_10_o,
   output logic [IDX_W:0]   lap_cnt,
   output logic [IDX_W-1:0] lap_idx,
   output logic             lap_full,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_STOP   = 2'b10,
      S_REVIEW = 2'b11
   } state_t;

   localparam logic [IDX_W:0] DEPTH_C = LAP_DEPTH[IDX_W:0];

   state_t           state_q, state_d;
   state_t           ret_q, ret_d;
   logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [IDX_W:0]   lap_cnt_q, lap_cnt_d;
   logic [IDX_W-1:0] lap_idx_q, lap_idx_d;
   logic             lap_full_q, lap_full_d;
   logic             cnt_en_q, cnt_en_d;
   logic             cnt_clr_q, cnt_clr_d;
   logic [18:0]      disp_q, disp_d;
   logic [18:0]      lap_mem_q [LAP_DEPTH];

   logic             wr_en;
   logic             clear;
   logic [IDX_W-1:0] oldest;
   logic [IDX_W-1:0] idx_inc;
   logic [18:0]      live;

   assign live    = {min_i, sec_i, ms_10_i};
   assign oldest  = lap_full_q ? wr_ptr_q : '0;
   assign idx_inc = lap_idx_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      ret_d     = ret_q;
      wr_ptr_d  = wr_ptr_q;
      lap_cnt_d = lap_cnt_q;
      lap_idx_d = lap_idx_q;
      wr_en     = 1'b0;
      clear     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_stop) begin
               state_d = S_RUN;
            end else if (review && lap_cnt_q != '0) begin
               state_d   = S_REVIEW;
               ret_d     = S_IDLE;
               lap_idx_d = oldest;
            end
         end
         S_RUN: begin
            if (lap_reset) begin
               wr_en    = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (lap_cnt_q != DEPTH_C) lap_cnt_d = lap_cnt_q + 1'b1;
            end
            if (start_stop) state_d = S_STOP;
         end
         S_STOP: begin
            if (lap_reset) begin
               clear = 1'b1;
            end else if (start_stop) begin
               state_d = S_RUN;
            end else if (review && lap_cnt_q != '0) begin
               state_d   = S_REVIEW;
               ret_d     = S_STOP;
               lap_idx_d = oldest;
            end
         end
         default: begin
            if (lap_reset) begin
               clear = 1'b1;
            end else if (start_stop) begin
               state_d = ret_q;
            end else if (review) begin
               // Slot after the newest is wr_ptr; wrap from there to the oldest.
               lap_idx_d = (idx_inc == wr_ptr_q) ? oldest : idx_inc;
            end
         end
      endcase
      if (clear) begin
         state_d   = S_IDLE;
         wr_ptr_d  = '0;
         lap_cnt_d = '0;
         lap_idx_d = '0;
      end
      cnt_clr_d  = clear;
      cnt_en_d   = (state_d == S_RUN);
      lap_full_d = (lap_cnt_d == DEPTH_C);
      disp_d     = (state_d == S_REVIEW) ? lap_mem_q[lap_idx_d] : live;
   end

   always_ff @(posedge clk_core) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         ret_q      <= S_IDLE;
         wr_ptr_q   <= '0;
         lap_cnt_q  <= '0;
         lap_idx_q  <= '0;
         lap_full_q <= 1'b0;
         cnt_en_q   <= 1'b0;
         cnt_clr_q  <= 1'b0;
         disp_q     <= '0;
      end else begin
         state_q    <= state_d;
         ret_q      <= ret_d;
         wr_ptr_q   <= wr_ptr_d;
         lap_cnt_q  <= lap_cnt_d;
         lap_idx_q  <= lap_idx_d;
         lap_full_q <= lap_full_d;
         cnt_en_q   <= cnt_en_d;
         cnt_clr_q  <= cnt_clr_d;
         disp_q     <= disp_d;
      end
   end

   // Lap storage is deliberately left out of reset.
   always_ff @(posedge clk_core) begin
      if (rst && wr_en) lap_mem_q[wr_ptr_q] <= live;
   end

   assign state_o  = state_q;
   assign cnt_en   = cnt_en_q;
   assign cnt_clr  = cnt_clr_q;
   assign lap_cnt  = lap_cnt_q;
   assign lap_idx  = lap_idx_q;
   assign lap_full = lap_full_q;
   assign {min_o, sec_o, ms_10_o} = disp_q;

endmodule
